// File: rtl/vector_cache_pkg.sv
// Shared types and constants for the vector cache reader.
package vector_cache_pkg;

  // Drain sequencer states
  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ISSUE = 2'd1,
    WAIT  = 2'd2,
    HOLD  = 2'd3
  } state_t;

  // Cycles from read address to registered read data
  localparam int RAM_LATENCY = 1;

endpackage

// File: rtl/ram_dual_port.sv
// Two-port cache storage: port a is a registered read, port b a write.
// A read and write to the same address in one cycle returns the old data.
module ram_dual_port #(
  parameter int DEPTH = 8,
  parameter int WIDTH = 256,
  localparam int AW   = $clog2(DEPTH)
) (
  input  logic             clk,
  input  logic             rd_en,
  input  logic [AW-1:0]    rd_addr,
  output logic [WIDTH-1:0] rd_data,
  input  logic             we_b,
  input  logic [AW-1:0]    addr_b,
  input  logic [WIDTH-1:0] data_b
);

  logic [WIDTH-1:0] mem [DEPTH];

  // Port b write
  always_ff @(posedge clk) begin
    if (we_b) mem[addr_b] <= data_b;
  end

  // Port a registered read
  always_ff @(posedge clk) begin
    if (rd_en) rd_data <= mem[rd_addr];
  end

endmodule

// File: rtl/vector_cache_reader.sv
// Drains a run of vectors from a small cache to a valid/ready consumer.
// Optional build macro: VECTOR_CACHE_READER_CLEAR_ON_READ_EN
//   defined   -> each entry is zeroed right after it is read, unless an
//                external write uses port b in that same cycle
//   undefined -> reads are non-destructive
//
// state | meaning
// IDLE  | waiting for a start with non-zero count
// ISSUE | read address driven at current pointer
// WAIT  | read data captured into vector_out, valid raised
// HOLD  | vector presented until the consumer takes it
module vector_cache_reader
  import vector_cache_pkg::*;
#(
  parameter int N          = 8,
  parameter int DATA_WIDTH = 32,
  parameter int MAX_CHAINS = 4,
  parameter int VVVRF_SIZE = 8,
  localparam int AW = $clog2(VVVRF_SIZE),
  localparam int CW = (MAX_CHAINS > 1) ? $clog2(MAX_CHAINS) : 1,
  localparam int VW = N * DATA_WIDTH
) (
  input  logic          clk,
  input  logic          reset_n,
  input  logic          wr_en,
  input  logic [AW-1:0] wr_addr,
  input  logic [VW-1:0] wr_vector,
  input  logic          start,
  input  logic [AW-1:0] start_addr,
  input  logic [AW:0]   count,
  input  logic [CW-1:0] chainId_in,
  input  logic          ready_in,
  output logic [VW-1:0] vector_out,
  output logic          valid_out,
  output logic          eof_out,
  output logic [CW-1:0] chainId_out,
  output logic          busy
);

  localparam logic [AW:0]   REM_ONE = (AW+1)'(1);
  localparam logic [AW-1:0] PTR_ONE = AW'(1);

  state_t        state_q, state_d;
  logic [AW-1:0] ptr_q;
  logic [AW:0]   rem_q;
  logic [CW-1:0] chain_q;
  logic          take_start, rd_en, load_out, advance;
  logic [VW-1:0] rd_data;
  logic          we_b;
  logic [AW-1:0] addr_b;
  logic [VW-1:0] data_b;

  // State register
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) state_q <= IDLE;
    else          state_q <= state_d;
  end

  // Next-state logic
  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:  if (start && (count != '0)) state_d = ISSUE;
      ISSUE: state_d = WAIT;
      WAIT:  state_d = HOLD;
      HOLD:  if (valid_out && ready_in) state_d = (rem_q == REM_ONE) ? IDLE : ISSUE;
      default: state_d = IDLE;
    endcase
  end

  // Control strobes decoded from the current state
  always_comb begin
    take_start = (state_q == IDLE) && start && (count != '0);
    rd_en      = (state_q == ISSUE);
    load_out   = (state_q == WAIT);
    advance    = (state_q == HOLD) && valid_out && ready_in;
  end

  assign busy = (state_q != IDLE);

  // Drain pointer, remaining count and chain tag
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      ptr_q   <= '0;
      rem_q   <= '0;
      chain_q <= '0;
    end else if (take_start) begin
      ptr_q   <= start_addr;
      rem_q   <= count;
      chain_q <= chainId_in;
    end else if (advance) begin
      ptr_q   <= ptr_q + PTR_ONE;
      rem_q   <= rem_q - REM_ONE;
    end
  end

  // Output registers; held stable across HOLD until the handshake
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      vector_out  <= '0;
      valid_out   <= 1'b0;
      eof_out     <= 1'b0;
      chainId_out <= '0;
    end else if (load_out) begin
      vector_out  <= rd_data;
      valid_out   <= 1'b1;
      eof_out     <= (rem_q == REM_ONE);
      chainId_out <= chain_q;
    end else if (advance) begin
      valid_out   <= 1'b0;
      eof_out     <= 1'b0;
    end
  end

`ifdef VECTOR_CACHE_READER_CLEAR_ON_READ_EN
  // Port b: external write has priority over the post-read clear
  always_comb begin
    we_b   = wr_en | load_out;
    addr_b = wr_en ? wr_addr : ptr_q;
    data_b = wr_en ? wr_vector : '0;
  end
`else
  // Port b carries external writes only
  always_comb begin
    we_b   = wr_en;
    addr_b = wr_addr;
    data_b = wr_vector;
  end
`endif

  ram_dual_port #(
    .DEPTH (VVVRF_SIZE),
    .WIDTH (VW)
  ) u_ram (
    .clk     (clk),
    .rd_en   (rd_en),
    .rd_addr (ptr_q),
    .rd_data (rd_data),
    .we_b    (we_b),
    .addr_b  (addr_b),
    .data_b  (data_b)
  );

endmodule

// File: tb/tb_vector_cache_reader.sv
// Scoreboard bench for vector_cache_reader.
module tb_vector_cache_reader;

  localparam int N  = 8;
  localparam int DW = 32;
  localparam int VW = N * DW;
  localparam int AW = 3;
  localparam int CW = 2;

  typedef struct {
    logic [VW-1:0] vec;
    logic          eof;
    logic [CW-1:0] chain;
  } exp_t;

  logic          clk = 1'b0;
  logic          reset_n = 1'b1;
  logic          wr_en = 1'b0;
  logic [AW-1:0] wr_addr = '0;
  logic [VW-1:0] wr_vector = '0;
  logic          start = 1'b0;
  logic [AW-1:0] start_addr = '0;
  logic [AW:0]   count = '0;
  logic [CW-1:0] chainId_in = '0;
  logic          ready_in = 1'b0;
  logic [VW-1:0] vector_out;
  logic          valid_out;
  logic          eof_out;
  logic [CW-1:0] chainId_out;
  logic          busy;

  int   checks = 0;
  int   errors = 0;
  exp_t exp_q[$];

  vector_cache_reader dut (
    .clk         (clk),
    .reset_n     (reset_n),
    .wr_en       (wr_en),
    .wr_addr     (wr_addr),
    .wr_vector   (wr_vector),
    .start       (start),
    .start_addr  (start_addr),
    .count       (count),
    .chainId_in  (chainId_in),
    .ready_in    (ready_in),
    .vector_out  (vector_out),
    .valid_out   (valid_out),
    .eof_out     (eof_out),
    .chainId_out (chainId_out),
    .busy        (busy)
  );

  always #5 clk = ~clk;

  function automatic logic [VW-1:0] exp_vec(int addr);
    logic [VW-1:0] v;
    for (int l = 0; l < N; l++) v[l*DW +: DW] = DW'(addr * 16 + l);
    return v;
  endfunction

  task automatic chk(string name, logic [VW-1:0] act, logic [VW-1:0] want);
    checks++;
    if (act !== want) begin
      errors++;
      $display("FAIL %s got %0h want %0h", name, act, want);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic write_entry(int addr, logic [VW-1:0] v);
    wr_en     = 1'b1;
    wr_addr   = AW'(addr);
    wr_vector = v;
    tick();
    wr_en     = 1'b0;
  endtask

  task automatic push_exp(logic [VW-1:0] v, logic eof, int chain);
    exp_t e;
    e.vec   = v;
    e.eof   = eof;
    e.chain = CW'(chain);
    exp_q.push_back(e);
  endtask

  task automatic push_drain(int addr, int cnt, int chain);
    for (int i = 0; i < cnt; i++) push_exp(exp_vec((addr + i) % 8), (i == cnt - 1), chain);
  endtask

  task automatic pulse_start(int addr, int cnt, int chain);
    start      = 1'b1;
    start_addr = AW'(addr);
    count      = (AW+1)'(cnt);
    chainId_in = CW'(chain);
    tick();
    start      = 1'b0;
  endtask

  task automatic wait_idle(string name);
    int n = 0;
    while (busy && n < 200) begin
      tick();
      n++;
    end
    chk({name, "_idle"}, VW'(busy), '0);
  endtask

  task automatic wait_valid(string name);
    int n = 0;
    while (!valid_out && n < 20) begin
      tick();
      n++;
    end
    chk({name, "_valid"}, VW'(valid_out), VW'(1));
  endtask

  // Monitor: every handshake is compared against the head of the queue
  always @(negedge clk) begin
    if (reset_n && valid_out && ready_in) begin
      checks++;
      if (exp_q.size() == 0) begin
        errors++;
        $display("FAIL unexpected_vector got %0h eof %0b chain %0d want none", vector_out, eof_out, chainId_out);
      end else begin
        exp_t e;
        e = exp_q.pop_front();
        if (vector_out !== e.vec || eof_out !== e.eof || chainId_out !== e.chain) begin
          errors++;
          $display("FAIL drain_vector got %0h eof %0b chain %0d want %0h eof %0b chain %0d",
                   vector_out, eof_out, chainId_out, e.vec, e.eof, e.chain);
        end
      end
    end
  end

  initial begin
    #1 reset_n = 1'b0;
    #2;
    chk("rst_valid", VW'(valid_out), '0);
    chk("rst_eof", VW'(eof_out), '0);
    chk("rst_busy", VW'(busy), '0);
    chk("rst_vector", vector_out, '0);
    chk("rst_chain", VW'(chainId_out), '0);
    tick();
    tick();
    reset_n = 1'b1;
    tick();

    for (int a = 0; a < 8; a++) write_entry(a, exp_vec(a));

    // Basic drain with latency check
    ready_in = 1'b1;
    push_drain(2, 3, 1);
    pulse_start(2, 3, 1);
    chk("lat_busy", VW'(busy), VW'(1));
    chk("lat_valid_e0", VW'(valid_out), '0);
    tick();
    chk("lat_valid_e1", VW'(valid_out), '0);
    tick();
    chk("lat_valid_e2", VW'(valid_out), VW'(1));
    wait_idle("basic");
    chk("basic_drained", VW'(exp_q.size()), '0);

    // Wrapping drain
    push_drain(6, 4, 2);
    pulse_start(6, 4, 2);
    wait_idle("wrap");
    chk("wrap_drained", VW'(exp_q.size()), '0);

    // Back-pressure on the first vector
    ready_in = 1'b0;
    push_drain(5, 2, 3);
    pulse_start(5, 2, 3);
    wait_valid("stall");
    for (int i = 0; i < 5; i++) begin
      chk("stall_valid", VW'(valid_out), VW'(1));
      chk("stall_vector", vector_out, exp_vec(5));
      chk("stall_eof", VW'(eof_out), '0);
      chk("stall_chain", VW'(chainId_out), VW'(3));
      tick();
    end
    ready_in = 1'b1;
    tick();
    chk("stall_single_hs", VW'(valid_out), '0);
    chk("stall_one_left", VW'(exp_q.size()), VW'(1));
    wait_idle("stall");

    // Zero-count start is ignored
    pulse_start(1, 0, 1);
    for (int i = 0; i < 4; i++) begin
      chk("zero_busy", VW'(busy), '0);
      tick();
    end

    // Start while busy is ignored
    push_drain(0, 3, 1);
    pulse_start(0, 3, 1);
    pulse_start(5, 2, 2);
    wait_idle("busy_start");
    chk("busy_start_drained", VW'(exp_q.size()), '0);
    repeat (4) tick();

    // Reset while holding the second of three vectors
    push_drain(4, 3, 2);
    pulse_start(4, 3, 2);
    begin
      int n = 0;
      while (exp_q.size() != 2 && n < 20) begin
        tick();
        n++;
      end
      chk("rst_mid_first", VW'(exp_q.size()), VW'(2));
    end
    ready_in = 1'b0;
    tick();
    wait_valid("rst_mid");
    #2 reset_n = 1'b0;
    #1;
    chk("rst_mid_valid", VW'(valid_out), '0);
    chk("rst_mid_eof", VW'(eof_out), '0);
    chk("rst_mid_busy", VW'(busy), '0);
    chk("rst_mid_vector", vector_out, '0);
    chk("rst_mid_chain", VW'(chainId_out), '0);
    exp_q.delete();
    tick();
    reset_n = 1'b1;
    ready_in = 1'b1;
    tick();
    for (int a = 0; a < 8; a++) write_entry(a, exp_vec(a));
    push_drain(0, 2, 3);
    pulse_start(0, 2, 3);
    wait_idle("post_rst");
    chk("post_rst_drained", VW'(exp_q.size()), '0);

    // Destructive-read behaviour on addr 3
    push_exp(exp_vec(3), 1'b1, 0);
    pulse_start(3, 1, 0);
    wait_idle("clr_first");
`ifdef VECTOR_CACHE_READER_CLEAR_ON_READ_EN
    push_exp('0, 1'b1, 0);
`else
    push_exp(exp_vec(3), 1'b1, 0);
`endif
    pulse_start(3, 1, 0);
    wait_idle("clr_second");

    // External write in the WAIT cycle wins over the clear
    write_entry(3, exp_vec(3));
    push_exp(exp_vec(3), 1'b1, 1);
    pulse_start(3, 1, 1);
    tick();
    chk("wait_state_valid", VW'(valid_out), '0);
    write_entry(5, {N{32'hA5A5_0005}});
    wait_idle("clr_race");
    push_exp(exp_vec(3), 1'b1, 1);
    pulse_start(3, 1, 1);
    wait_idle("clr_keep3");
    push_exp({N{32'hA5A5_0005}}, 1'b1, 2);
    pulse_start(5, 1, 2);
    wait_idle("clr_wr5");
    chk("final_drained", VW'(exp_q.size()), '0);

    repeat (3) tick();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/vector_cache_reader.md
VECTOR_CACHE_READER -- requirements
Module: vector_cache_reader

Interface
REQ-001 Param N, default 8, vector lanes.
REQ-002 Param DATA_WIDTH, default 32, bits per lane.
REQ-003 Param MAX_CHAINS, default 4, chain IDs supported.
REQ-004 Param VVVRF_SIZE, default 8, cache entries (power of 2); AW=$clog2(VVVRF_SIZE).
REQ-005 clk  in  1  sole clock, all logic on rising edge.
REQ-006 reset_n  in  1  asynchronous, active-low reset.
REQ-007 wr_en  in  1  cache write strobe.
REQ-008 wr_addr  in  AW  cache write address.
REQ-009 wr_vector  in  N x DATA_WIDTH  cache write data.
REQ-010 start  in  1  drain request pulse.
REQ-011 start_addr  in  AW  first entry to drain.
REQ-012 count  in  AW+1  number of vectors to drain.
REQ-013 chainId_in  in  $clog2(MAX_CHAINS)  chain tag for the drain.
REQ-014 ready_in  in  1  downstream accepts vector_out.
REQ-015 vector_out  out  N x DATA_WIDTH  drained vector.
REQ-016 valid_out  out  1  vector_out valid.
REQ-017 eof_out  out  1  marks last vector of a drain.
REQ-018 chainId_out  out  $clog2(MAX_CHAINS)  chain tag of the drain.
REQ-019 busy  out  1  drain in progress (state != IDLE).

Function
REQ-020 Cache is VVVRF_SIZE x (N*DATA_WIDTH), read latency 1 cycle; wr_en writes wr_vector to wr_addr in every state.
REQ-021 FSM states IDLE, ISSUE, WAIT, HOLD.
REQ-022 IDLE: start with count!=0 latches start_addr, count, chainId_in -> ISSUE; start with count==0 is ignored.
REQ-023 ISSUE: drive the read address at the current pointer -> WAIT.
REQ-024 WAIT: RAM data is registered into vector_out, valid_out=1, eof_out=(remaining==1), chainId_out=latched tag -> HOLD.
REQ-025 HOLD: vector_out, eof_out, chainId_out stay stable while valid_out=1 and ready_in=0.
REQ-026 HOLD handshake (valid_out & ready_in): valid_out=0 next cycle, pointer+1 modulo VVVRF_SIZE, remaining-1; if remaining was 1 -> IDLE, else -> ISSUE.
REQ-027 Minimum spacing is 3 cycles per vector; start-to-first valid_out is 2 cycles.
REQ-028 count > VVVRF_SIZE wraps the pointer and re-reads entries in order.
REQ-029 start while busy=1 is ignored, with no change to latched values.
REQ-030 Write and read to the same address in the same cycle return the old data.
REQ-031 A write to an entry already issued does not alter the vector held in HOLD.

Reset
REQ-032 reset_n low asynchronously forces: state=IDLE, valid_out=0, eof_out=0, busy=0, vector_out=0, chainId_out=0, pointer=0, remaining=0.
REQ-033 Reset mid-drain aborts the drain; no eof_out is emitted; cache contents are undefined after reset.

Configuration
REQ-034 Macro VECTOR_CACHE_READER_CLEAR_ON_READ_EN.
REQ-035 Defined: in WAIT, the entry just read is written to zero via the second RAM port; if wr_en targets any address that cycle, the external write wins and the clear is dropped.
REQ-036 Undefined: reads are non-destructive and the second port is used only for wr_en.

Structure
REQ-037 Shared package vector_cache_pkg holds the FSM state enum typedef and the constant RAM_LATENCY=1.
REQ-038 Storage is one ram_dual_port instance: port a for reads, port b for writes and clears; FSM, pointer and output registers live in vector_cache_reader.

Verification
REQ-039 Write entries 0..7 with lane value = addr*16+lane; start addr=2, count=3, chain=1, ready_in=1 -> three vectors from addrs 2, 3, 4, chainId_out=1, eof_out only on addr 4, busy falls after the third handshake.
REQ-040 start addr=6, count=4 -> vectors from addrs 6, 7, 0, 1 (wrap).
REQ-041 Hold ready_in=0 for 5 cycles on the first vector -> vector_out stable and valid_out=1 throughout; exactly one handshake once ready_in=1.
REQ-042 start with count=0 -> busy stays 0, no valid_out; start with count=2 while busy -> ignored, original drain completes unchanged.
REQ-043 Assert reset_n=0 during HOLD of the 2nd of 3 vectors -> outputs zero asynchronously, state IDLE, no eof_out; a new drain after release works.
REQ-044 With CLEAR_EN defined, drain addr 3 count 1, then drain it again -> second read returns all zeros; repeat with wr_en=1 to addr 5 in the WAIT cycle -> addr 3 keeps its data and addr 5 is written.
